// File: rtl/sc_pkg.sv
// sc_pkg: shared types and constants for the stochastic decode path
package sc_pkg;
  typedef enum logic [1:0] {SC_IDLE, SC_RUN, SC_HOLD} sc_state_t;
  localparam int SC_WIDTH = 16;
  function automatic logic [4:0] sc_clamp(input logic [4:0] len, input int max_log);
    return len == 5'd0 ? 5'd1 : int'(len) > max_log ? 5'(max_log) : len;
  endfunction
endpackage

// File: rtl/sc_stream_decoder_if.sv
// sc_stream_decoder_if: start/done request side plus valid/ready result side
interface sc_stream_decoder_if import sc_pkg::*; #(parameter int WIDTH = SC_WIDTH);
  logic start;
  logic [4:0] len_log2;
  logic bit_valid;
  logic bit1;
  logic bit2;
  logic busy;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  modport master(output start, len_log2, bit_valid, bit1, bit2, out_ready, input busy, out_valid, val1, val2);
  modport slave(input start, len_log2, bit_valid, bit1, bit2, out_ready, output busy, out_valid, val1, val2);
endinterface

// File: rtl/sc_ones_counter.sv
// sc_ones_counter: per-channel ones counter with saturating scale of the post-update count
module sc_ones_counter import sc_pkg::*; #(
  parameter int WIDTH   = SC_WIDTH,
  parameter int MAX_LOG = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  input  logic [4:0]       l,
  output logic [WIDTH-1:0] scaled
);
  logic [MAX_LOG:0] count, nxt;
  // scaled reflects the count including this cycle's sample, so the final sample lands in the result
  always_comb begin
    nxt = clear ? '0 : count + (MAX_LOG+1)'(en && bit_in);
    scaled = nxt == ((MAX_LOG+1)'(1) << l) ? '1 : WIDTH'(nxt) << (WIDTH - int'(l));
  end
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else count <= nxt;
endmodule

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts ones on two stochastic streams over 2^L samples and returns scaled estimates
module sc_stream_decoder import sc_pkg::*; #(
  parameter int WIDTH   = SC_WIDTH,
  parameter int MAX_LOG = 16
) (
  input logic clk,
  input logic reset,
  sc_stream_decoder_if.slave bus
);
  sc_state_t state, nxt;
  logic [4:0] l_q;
  logic [MAX_LOG:0] samples;
  logic clear, en, last;
  logic [WIDTH-1:0] s1, s2, v1, v2;
  always_comb begin
    last = samples + 1'b1 == ((MAX_LOG+1)'(1) << l_q);
    clear = state == SC_IDLE && bus.start;
    en = state == SC_RUN && bus.bit_valid;
    nxt = state == SC_IDLE ? (bus.start ? SC_RUN : SC_IDLE) :
          state == SC_RUN  ? (en && last ? SC_HOLD : SC_RUN) :
                             (bus.out_ready ? SC_IDLE : SC_HOLD);
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= SC_IDLE;
      l_q <= 5'd1;
      samples <= '0;
      v1 <= '0;
      v2 <= '0;
    end else begin
      state <= nxt;
      if (clear) begin
        samples <= '0;
        l_q <= sc_clamp(bus.len_log2, MAX_LOG);
      end else if (en) samples <= samples + 1'b1;
      if (en && last) begin
        v1 <= s1;
        v2 <= s2;
      end
    end
  sc_ones_counter #(.WIDTH(WIDTH), .MAX_LOG(MAX_LOG)) u_ch1 (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .bit_in(bus.bit1), .l(l_q), .scaled(s1));
  sc_ones_counter #(.WIDTH(WIDTH), .MAX_LOG(MAX_LOG)) u_ch2 (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .bit_in(bus.bit2), .l(l_q), .scaled(s2));
  assign bus.busy = state != SC_IDLE;
  assign bus.out_valid = state == SC_HOLD;
  assign bus.val1 = v1;
  assign bus.val2 = v2;
endmodule
